// File: rtl/register_file.sv
// 32 x 32-bit MIPS general-purpose register file for the decode stage.
// Two combinational read ports, one synchronous write port, $0 tied to zero, write-back bypass.
module register_file (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RegWrite,
   input  logic [4:0]  rdReg1,
   input  logic [4:0]  rdReg2,
   input  logic [4:0]  writeReg,
   input  logic [31:0] writeData,
   output logic [31:0] rdData1,
   output logic [31:0] rdData2
);

   logic [31:0] r_regs [32];
   logic        w_wr_en;

   // A write is effective only out of reset and never to $0; the same qualifier gates the bypass.
   assign w_wr_en = rst_n & RegWrite & (writeReg != 5'd0);

   // Storage update: synchronous clear on reset, otherwise the qualified write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= 32'd0;
         end
      end else if (w_wr_en) begin
         r_regs[writeReg] <= writeData;
      end
   end

   // Read port 1: zero for $0, bypassed write-back data on address match, else array contents.
   always_comb begin
      rdData1 = 32'd0;
      if (rdReg1 == 5'd0) begin
         rdData1 = 32'd0;
      end else if (w_wr_en && (writeReg == rdReg1)) begin
         rdData1 = writeData;
      end else begin
         rdData1 = r_regs[rdReg1];
      end
   end

   // Read port 2: same selection as port 1, fully independent.
   always_comb begin
      rdData2 = 32'd0;
      if (rdReg2 == 5'd0) begin
         rdData2 = 32'd0;
      end else if (w_wr_en && (writeReg == rdReg2)) begin
         rdData2 = writeData;
      end else begin
         rdData2 = r_regs[rdReg2];
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_register_file;

   logic        clk;
   logic        rst_n;
   logic        RegWrite;
   logic [4:0]  rdReg1;
   logic [4:0]  rdReg2;
   logic [4:0]  writeReg;
   logic [31:0] writeData;
   logic [31:0] rdData1;
   logic [31:0] rdData2;

   int total;
   int bad;
   bit model_ok;
   logic [31:0] mem_m [32];

   register_file dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .RegWrite  (RegWrite),
      .rdReg1    (rdReg1),
      .rdReg2    (rdReg2),
      .writeReg  (writeReg),
      .writeData (writeData),
      .rdData1   (rdData1),
      .rdData2   (rdData2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected read value from the architectural rules and the current inputs.
   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (rst_n && RegWrite && writeReg == a) return writeData;
      return mem_m[a];
   endfunction

   // One clock: drive, check reads before the edge, take the edge, update the model.
   task automatic cyc(input logic rn, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
      rst_n = rn; RegWrite = we; writeReg = wa; writeData = wd;
      rdReg1 = a1; rdReg2 = a2;
      #1;
      if (model_ok) begin
         check_val("rd1", rdData1, exp_rd(a1));
         check_val("rd2", rdData2, exp_rd(a2));
      end
      @(posedge clk);
      if (!rn) begin
         for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
         model_ok = 1'b1;
      end else if (we && wa != 5'd0) begin
         mem_m[wa] = wd;
      end
      @(negedge clk);
   endtask

   // Present read addresses with no write and settle, no clock edge.
   task automatic peek(input logic [4:0] a1, input logic [4:0] a2);
      rst_n = 1'b1; RegWrite = 1'b0; rdReg1 = a1; rdReg2 = a2;
      #1;
   endtask

   initial begin
      total = 0; bad = 0; model_ok = 1'b0;
      rst_n = 1'b0; RegWrite = 1'b0; writeReg = 5'd0; writeData = 32'd0;
      rdReg1 = 5'd0; rdReg2 = 5'd0;
      @(negedge clk);

      // Initial reset, then fill with random data, then reset again.
      cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      for (int i = 1; i < 32; i++) cyc(1'b1, 1'b1, 5'(i), $urandom, 5'(i), 5'(32 - i));
      cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd17);
      for (int i = 0; i < 32; i++) begin
         peek(5'(i), 5'(31 - i));
         check_val("reset_p1", rdData1, 32'd0);
         check_val("reset_p2", rdData2, 32'd0);
      end

      // Basic write/read.
      cyc(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
      cyc(1'b1, 1'b1, 5'd31, 32'h12345678, 5'd0, 5'd0);
      peek(5'd5, 5'd31);
      check_val("basic_r5", rdData1, 32'hDEADBEEF);
      check_val("basic_r31", rdData2, 32'h12345678);

      // $0 protection, same cycle and afterwards.
      cyc(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      peek(5'd0, 5'd0);
      check_val("zero_p1", rdData1, 32'd0);
      check_val("zero_p2", rdData2, 32'd0);

      // Bypass: visible before the edge and held after it.
      cyc(1'b1, 1'b1, 5'd7, 32'h11111111, 5'd7, 5'd7);
      rst_n = 1'b1; RegWrite = 1'b1; writeReg = 5'd7; writeData = 32'hA5A5A5A5;
      rdReg1 = 5'd7; rdReg2 = 5'd7;
      #1;
      check_val("byp_pre_p1", rdData1, 32'hA5A5A5A5);
      check_val("byp_pre_p2", rdData2, 32'hA5A5A5A5);
      cyc(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
      peek(5'd7, 5'd7);
      check_val("byp_post_p1", rdData1, 32'hA5A5A5A5);
      check_val("byp_post_p2", rdData2, 32'hA5A5A5A5);

      // Write disabled.
      cyc(1'b1, 1'b1, 5'd9, 32'h00000042, 5'd0, 5'd0);
      writeReg = 5'd9; writeData = 32'hCAFEF00D;
      peek(5'd9, 5'd9);
      check_val("wdis_pre", rdData1, 32'h00000042);
      cyc(1'b1, 1'b0, 5'd9, 32'hCAFEF00D, 5'd9, 5'd9);
      peek(5'd9, 5'd9);
      check_val("wdis_post", rdData2, 32'h00000042);

      // Reset overrides write; bypass disabled while in reset.
      cyc(1'b1, 1'b1, 5'd3, 32'h77777777, 5'd0, 5'd0);
      rst_n = 1'b0; RegWrite = 1'b1; writeReg = 5'd3; writeData = 32'h55555555;
      rdReg1 = 5'd3; rdReg2 = 5'd3;
      #1;
      check_val("rst_nobyp", rdData1, 32'h77777777);
      cyc(1'b0, 1'b1, 5'd3, 32'h55555555, 5'd3, 5'd3);
      peek(5'd3, 5'd3);
      check_val("rst_ovr", rdData1, 32'd0);

      // Randomized traffic; narrow address range half the time to force bypass hits.
      for (int n = 0; n < 400; n++) begin
         logic narrow;
         logic [4:0] wa, a1, a2;
         narrow = 1'($urandom_range(0, 1));
         wa = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
         a1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
         a2 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
         cyc(($urandom_range(0, 99) != 0), 1'($urandom), wa, $urandom, a1, a2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
